// File: rtl/udp_vlg_tx_hdr_if.sv
// Bundle between the UDP transmit controller, this header stage and the IPv4 transmit stage.
// master drives the upstream datagram and downstream request; slave is the header stage itself.
interface udp_vlg_tx_hdr_if;
    logic        in_rdy;
    logic        in_req;
    logic [15:0] in_src_port;
    logic [15:0] in_dst_port;
    logic [15:0] in_length;
    logic [15:0] in_cks;
    logic [7:0]  in_dat;
    logic        in_val;
    logic        in_sof;
    logic        in_eof;
    logic        out_rdy;
    logic        out_req;
    logic [15:0] out_length;
    logic [7:0]  out_dat;
    logic        out_val;
    logic        out_sof;
    logic        out_eof;
    logic        err;

    modport slave (
        input  in_rdy, in_src_port, in_dst_port, in_length, in_cks,
        input  in_dat, in_val, in_sof, in_eof, out_req,
        output in_req, out_rdy, out_length, out_dat, out_val, out_sof, out_eof, err
    );

    modport master (
        output in_rdy, in_src_port, in_dst_port, in_length, in_cks,
        output in_dat, in_val, in_sof, in_eof, out_req,
        input  in_req, out_rdy, out_length, out_dat, out_val, out_sof, out_eof, err
    );
endinterface

// File: rtl/udp_vlg_tx_hdr.sv
// UDP header prepend: 8-byte UDP header followed by the upstream payload as one byte stream.
// Latency: header byte 0 one cycle after out_req; payload registered, one cycle in to out.
// Backpressure: none inside a frame; out_rdy/out_req gate frame start, in_req pulls the payload.
module udp_vlg_tx_hdr #(
    parameter int MTU     = 1500,
    parameter int TIMEOUT = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    udp_vlg_tx_hdr_if.slave io_udp
);

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] cks;
    } hdr_t;

    typedef enum logic [2:0] {idle_s, pend_s, hdr_s, pld_s, drop_s} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MTU - 20);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state, w_state;
    hdr_t        r_hdr, w_hdr;
    logic [2:0]  r_cnt, w_cnt;
    logic [15:0] r_pcnt, w_pcnt;
    logic [15:0] r_tcnt, w_tcnt;
    logic        r_in_req, w_in_req;
    logic        r_out_rdy, w_out_rdy;
    logic [15:0] r_out_len, w_out_len;
    logic [7:0]  r_out_dat, w_out_dat;
    logic        r_out_val, w_out_val;
    logic        r_out_sof, w_out_sof;
    logic        r_out_eof, w_out_eof;
    logic        r_err, w_err;

    logic [7:0]  w_hdr_byte;
    logic [15:0] w_plen;
    logic        w_hdr_only;
    logic        w_bad_len;

    assign w_plen     = r_hdr.len - 16'd8;
    assign w_hdr_only = (r_hdr.len == 16'd8);
    assign w_bad_len  = (io_udp.in_length < 16'd8) || (io_udp.in_length > MAX_LEN);

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_cnt)
            3'd0: w_hdr_byte = r_hdr.src[15:8];
            3'd1: w_hdr_byte = r_hdr.src[7:0];
            3'd2: w_hdr_byte = r_hdr.dst[15:8];
            3'd3: w_hdr_byte = r_hdr.dst[7:0];
            3'd4: w_hdr_byte = r_hdr.len[15:8];
            3'd5: w_hdr_byte = r_hdr.len[7:0];
            3'd6: w_hdr_byte = r_hdr.cks[15:8];
            3'd7: w_hdr_byte = r_hdr.cks[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state   = r_state;
        w_hdr     = r_hdr;
        w_cnt     = r_cnt;
        w_pcnt    = r_pcnt;
        w_tcnt    = r_tcnt;
        w_out_rdy = r_out_rdy;
        w_out_len = r_out_len;
        w_out_dat = r_out_dat;
        w_in_req  = 1'b0;
        w_out_val = 1'b0;
        w_out_sof = 1'b0;
        w_out_eof = 1'b0;
        w_err     = 1'b0;

        case (r_state)
            idle_s: begin
                if (io_udp.in_rdy) begin
                    w_hdr     = '{src: io_udp.in_src_port, dst: io_udp.in_dst_port,
                                  len: io_udp.in_length,   cks: io_udp.in_cks};
                    w_out_len = io_udp.in_length;
                    w_tcnt    = '0;
                    if (w_bad_len) begin
                        w_state  = drop_s;
                        w_in_req = 1'b1;
                        w_err    = 1'b1;
                    end else begin
                        w_state   = pend_s;
                        w_out_rdy = 1'b1;
                    end
                end
            end

            pend_s: begin
                if (io_udp.out_req) begin
                    w_out_rdy = 1'b0;
                    w_out_dat = r_hdr.src[15:8];
                    w_out_val = 1'b1;
                    w_out_sof = 1'b1;
                    w_cnt     = 3'd1;
                    w_state   = hdr_s;
                end
            end

            hdr_s: begin
                w_out_dat = w_hdr_byte;
                w_out_val = 1'b1;
                w_cnt     = r_cnt + 3'd1;
                // payload request timed so the first byte lands right after header byte 7
                if (r_cnt == 3'd6 && !w_hdr_only)
                    w_in_req = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_pcnt = '0;
                    w_tcnt = '0;
                    if (w_hdr_only) begin
                        w_out_eof = 1'b1;
                        w_state   = idle_s;
                    end else begin
                        w_state = pld_s;
                    end
                end
            end

            pld_s: begin
                if (io_udp.in_val) begin
                    w_out_dat = io_udp.in_dat;
                    w_out_val = 1'b1;
                    w_tcnt    = '0;
                    if (r_pcnt != w_plen)
                        w_pcnt = r_pcnt + 16'd1;
                    if (io_udp.in_eof) begin
                        w_out_eof = 1'b1;
                        w_err     = (r_pcnt + 16'd1 != w_plen);
                        w_state   = idle_s;
                    end
                end else if (r_tcnt == TO_LAST) begin
                    w_out_dat = 8'h00;
                    w_out_val = 1'b1;
                    w_out_eof = 1'b1;
                    w_err     = 1'b1;
                    w_state   = idle_s;
                end else begin
                    w_tcnt = r_tcnt + 16'd1;
                end
            end

            drop_s: begin
                if (io_udp.in_val) begin
                    w_tcnt = '0;
                    if (io_udp.in_eof)
                        w_state = idle_s;
                end else if (r_tcnt == TO_LAST) begin
                    w_state = idle_s;
                end else begin
                    w_tcnt = r_tcnt + 16'd1;
                end
            end

            default: w_state = idle_s;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= idle_s;
            r_hdr     <= '0;
            r_cnt     <= '0;
            r_pcnt    <= '0;
            r_tcnt    <= '0;
            r_in_req  <= 1'b0;
            r_out_rdy <= 1'b0;
            r_out_len <= '0;
            r_out_dat <= '0;
            r_out_val <= 1'b0;
            r_out_sof <= 1'b0;
            r_out_eof <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_hdr     <= w_hdr;
            r_cnt     <= w_cnt;
            r_pcnt    <= w_pcnt;
            r_tcnt    <= w_tcnt;
            r_in_req  <= w_in_req;
            r_out_rdy <= w_out_rdy;
            r_out_len <= w_out_len;
            r_out_dat <= w_out_dat;
            r_out_val <= w_out_val;
            r_out_sof <= w_out_sof;
            r_out_eof <= w_out_eof;
            r_err     <= w_err;
        end
    end

    assign io_udp.in_req     = r_in_req;
    assign io_udp.out_rdy    = r_out_rdy;
    assign io_udp.out_length = r_out_len;
    assign io_udp.out_dat    = r_out_dat;
    assign io_udp.out_val    = r_out_val;
    assign io_udp.out_sof    = r_out_sof;
    assign io_udp.out_eof    = r_out_eof;
    assign io_udp.err        = r_err;

endmodule

// File: tb/tb_udp_vlg_tx_hdr.sv
// Bench for udp_vlg_tx_hdr: cycle tables of {inputs, expected outputs} plus hand-driven
// underrun and mid-frame reset sequences.
module tb_udp_vlg_tx_hdr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_vlg_tx_hdr_if bus();

    udp_vlg_tx_hdr #(.MTU(1500), .TIMEOUT(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_udp (bus)
    );

    // ictl = {in_rdy, out_req, in_val, in_eof}
    // xctl = {in_req, out_rdy, out_val, out_sof, out_eof, err} expected in the following cycle
    typedef struct {
        logic [15:0] src, dst, len, cks;
        logic [3:0]  ictl;
        logic [7:0]  idat;
        logic [5:0]  xctl;
        logic [7:0]  xdat;
    } vec_t;

    vec_t        tbl[$];
    int          seg[8];
    logic [15:0] m_src, m_dst, m_len, m_cks;
    int          checks = 0;
    int          errors = 0;

    task automatic meta(input logic [15:0] s, d, l, c);
        m_src = s; m_dst = d; m_len = l; m_cks = c;
    endtask

    task automatic add(input logic [3:0] ictl, input logic [7:0] idat,
                       input logic [5:0] xctl, input logic [7:0] xdat);
        vec_t v;
        v.src = m_src; v.dst = m_dst; v.len = m_len; v.cks = m_cks;
        v.ictl = ictl; v.idat = idat; v.xctl = xctl; v.xdat = xdat;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] ictl, input logic [7:0] idat);
        @(negedge clk);
        bus.in_rdy      = ictl[3];
        bus.out_req     = ictl[2];
        bus.in_val      = ictl[1];
        bus.in_eof      = ictl[0];
        bus.in_sof      = 1'b0;
        bus.in_dat      = idat;
        bus.in_src_port = m_src;
        bus.in_dst_port = m_dst;
        bus.in_length   = m_len;
        bus.in_cks      = m_cks;
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        vec_t v;
        for (int i = lo; i < hi; i++) begin
            v = tbl[i];
            meta(v.src, v.dst, v.len, v.cks);
            cyc(v.ictl, v.idat);
            chk("ctl", i, 32'({bus.in_req, bus.out_rdy, bus.out_val, bus.out_sof,
                               bus.out_eof, bus.err}), 32'(v.xctl));
            if (v.xctl[3]) chk("dat", i, 32'(bus.out_dat), 32'(v.xdat));
            if (v.xctl[4]) chk("len", i, 32'(bus.out_length), 32'(v.len));
        end
    endtask

    task automatic fill;
        // normal frame, 4 payload bytes
        seg[0] = tbl.size();
        meta(16'h1234, 16'h0050, 16'd12, 16'h0000);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b0000, 8'h00, 6'b010000, 8'h00);
        add(4'b0100, 8'h00, 6'b001100, 8'h12);
        add(4'b0000, 8'h00, 6'b001000, 8'h34);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h50);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h0C);
        add(4'b0000, 8'h00, 6'b101000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0010, 8'hAA, 6'b001000, 8'hAA);
        add(4'b0010, 8'hBB, 6'b001000, 8'hBB);
        add(4'b0010, 8'hCC, 6'b001000, 8'hCC);
        add(4'b0011, 8'hDD, 6'b001010, 8'hDD);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        // header only
        seg[1] = tbl.size();
        meta(16'hA1A2, 16'hB1B2, 16'd8, 16'hC1C2);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b0100, 8'h00, 6'b001100, 8'hA1);
        add(4'b0000, 8'h00, 6'b001000, 8'hA2);
        add(4'b0000, 8'h00, 6'b001000, 8'hB1);
        add(4'b0000, 8'h00, 6'b001000, 8'hB2);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h08);
        add(4'b0000, 8'h00, 6'b001000, 8'hC1);
        add(4'b0000, 8'h00, 6'b001010, 8'hC2);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        // reject len=5, drained by eof
        seg[2] = tbl.size();
        meta(16'h0001, 16'h0002, 16'd5, 16'h0000);
        add(4'b1000, 8'h00, 6'b100001, 8'h00);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        add(4'b0010, 8'h11, 6'b000000, 8'h00);
        add(4'b0011, 8'h22, 6'b000000, 8'h00);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        // reject len=1500, drained by timeout, then a len=10 frame
        seg[3] = tbl.size();
        meta(16'h0001, 16'h0002, 16'd1500, 16'h0000);
        add(4'b1000, 8'h00, 6'b100001, 8'h00);
        for (int k = 0; k < 7; k++) add(4'b0000, 8'h00, 6'b000000, 8'h00);
        meta(16'h0102, 16'h0304, 16'd10, 16'hBEEF);
        add(4'b1000, 8'h00, 6'b000000, 8'h00);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b0100, 8'h00, 6'b001100, 8'h01);
        add(4'b0000, 8'h00, 6'b001000, 8'h02);
        add(4'b0000, 8'h00, 6'b001000, 8'h03);
        add(4'b0000, 8'h00, 6'b001000, 8'h04);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h0A);
        add(4'b0000, 8'h00, 6'b101000, 8'hBE);
        add(4'b0000, 8'h00, 6'b001000, 8'hEF);
        add(4'b0010, 8'h5A, 6'b001000, 8'h5A);
        add(4'b0011, 8'h6B, 6'b001010, 8'h6B);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        // early eof: 2 of 3 payload bytes
        seg[4] = tbl.size();
        meta(16'hFFFF, 16'h0001, 16'd11, 16'h1234);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b0100, 8'h00, 6'b001100, 8'hFF);
        add(4'b0000, 8'h00, 6'b001000, 8'hFF);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h01);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h0B);
        add(4'b0000, 8'h00, 6'b101000, 8'h12);
        add(4'b0000, 8'h00, 6'b001000, 8'h34);
        add(4'b0010, 8'h77, 6'b001000, 8'h77);
        add(4'b0011, 8'h88, 6'b001011, 8'h88);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        // back-to-back with in_rdy held
        seg[5] = tbl.size();
        meta(16'h1111, 16'h2222, 16'd10, 16'h0000);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b1100, 8'h00, 6'b001100, 8'h11);
        add(4'b1000, 8'h00, 6'b001000, 8'h11);
        add(4'b1000, 8'h00, 6'b001000, 8'h22);
        add(4'b1000, 8'h00, 6'b001000, 8'h22);
        add(4'b1000, 8'h00, 6'b001000, 8'h00);
        add(4'b1000, 8'h00, 6'b001000, 8'h0A);
        add(4'b1000, 8'h00, 6'b101000, 8'h00);
        add(4'b1000, 8'h00, 6'b001000, 8'h00);
        add(4'b1010, 8'h01, 6'b001000, 8'h01);
        meta(16'h3333, 16'h4444, 16'd10, 16'h0000);
        add(4'b1011, 8'h02, 6'b001010, 8'h02);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b1100, 8'h00, 6'b001100, 8'h33);
        add(4'b0000, 8'h00, 6'b001000, 8'h33);
        add(4'b0000, 8'h00, 6'b001000, 8'h44);
        add(4'b0000, 8'h00, 6'b001000, 8'h44);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h0A);
        add(4'b0000, 8'h00, 6'b101000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0010, 8'h03, 6'b001000, 8'h03);
        add(4'b0011, 8'h04, 6'b001010, 8'h04);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        // frame following a mid-frame reset
        seg[6] = tbl.size();
        meta(16'h0A0B, 16'h0C0D, 16'd10, 16'hFFFF);
        add(4'b1000, 8'h00, 6'b010000, 8'h00);
        add(4'b0100, 8'h00, 6'b001100, 8'h0A);
        add(4'b0000, 8'h00, 6'b001000, 8'h0B);
        add(4'b0000, 8'h00, 6'b001000, 8'h0C);
        add(4'b0000, 8'h00, 6'b001000, 8'h0D);
        add(4'b0000, 8'h00, 6'b001000, 8'h00);
        add(4'b0000, 8'h00, 6'b001000, 8'h0A);
        add(4'b0000, 8'h00, 6'b101000, 8'hFF);
        add(4'b0000, 8'h00, 6'b001000, 8'hFF);
        add(4'b0010, 8'hE1, 6'b001000, 8'hE1);
        add(4'b0011, 8'hE2, 6'b001010, 8'hE2);
        add(4'b0000, 8'h00, 6'b000000, 8'h00);
        seg[7] = tbl.size();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 0, 32'({bus.in_req, bus.out_rdy, bus.out_val, bus.out_sof,
                                  bus.out_eof, bus.err}), 32'd0);
        chk({nm, "_dat"}, 0, 32'(bus.out_dat), 32'd0);
        chk({nm, "_len"}, 0, 32'(bus.out_length), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        rst = 1'b1;
        meta(16'h0, 16'h0, 16'h0, 16'h0);
        fill();
        cyc(4'b0000, 8'h00);
        cyc(4'b0000, 8'h00);
        chk_zero("reset");
        rst = 1'b0;

        run_rows(seg[0], seg[6]);

        // underrun: 2 of 4 payload bytes then in_val stays low
        meta(16'hCAFE, 16'hF00D, 16'd12, 16'h0000);
        cyc(4'b1000, 8'h00);
        chk("ur_ordy", 0, 32'(bus.out_rdy), 32'd1);
        cyc(4'b0100, 8'h00);
        chk("ur_sof", 0, 32'({bus.out_sof, bus.out_dat}), 32'h1CA);
        repeat (7) cyc(4'b0000, 8'h00);
        cyc(4'b0010, 8'hAA);
        cyc(4'b0010, 8'hBB);
        chk("ur_dat", 0, 32'(bus.out_dat), 32'hBB);
        gap = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(4'b0000, 8'h00);
            if (bus.out_val) begin
                gap = n;
                break;
            end
        end
        chk("ur_gap", 0, 32'(gap), 32'd8);
        chk("ur_abort", 0, 32'({bus.out_eof, bus.err, bus.out_dat}), 32'h300);
        cyc(4'b0000, 8'h00);
        chk("ur_after", 0, 32'({bus.out_val, bus.err}), 32'd0);

        // back in idle: start a frame and reset it at T+4
        meta(16'h5555, 16'h6666, 16'd10, 16'h0000);
        cyc(4'b1000, 8'h00);
        chk("mr_ordy", 0, 32'(bus.out_rdy), 32'd1);
        cyc(4'b0100, 8'h00);
        repeat (3) cyc(4'b0000, 8'h00);
        chk("mr_dat", 0, 32'(bus.out_dat), 32'h66);
        rst = 1'b1;
        cyc(4'b0000, 8'h00);
        chk_zero("mid_rst");
        rst = 1'b0;

        run_rows(seg[6], seg[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_vlg_tx_hdr.md
# udp_vlg_tx_hdr

Downstream neighbour of the UDP transmit controller: accepts a pending UDP datagram (metadata plus payload byte stream via rdy/req handshake), prepends the 8-byte UDP header, and presents a single contiguous header+payload byte stream to the IPv4 transmit stage through the same rdy/req handshake. It adds no buffering beyond one register stage. It detects upstream stream underrun with a watchdog and terminates the frame cleanly.

## Interface
Parameters:
- `MTU`, 1500: maximum IPv4 packet size in bytes; bounds the accepted UDP length.
- `TIMEOUT`, 8: cycles without `in_val` during payload before abort.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `in_rdy`, in, 1: upstream has a datagram pending; metadata valid while high.
- `in_req`, out, 1: one-cycle pulse requesting upstream payload; first byte arrives the next cycle.
- `in_src_port`, `in_dst_port`, in, 16 each: UDP ports.
- `in_length`, in, 16: UDP length including the 8-byte header.
- `in_cks`, in, 16: UDP checksum; emitted verbatim, 0 means none.
- `in_dat`, in, 8: upstream payload byte.
- `in_val`, `in_sof`, `in_eof`, in, 1 each: upstream stream qualifiers.
- `out_rdy`, out, 1: a header-prefixed datagram is ready for the IPv4 stage.
- `out_req`, in, 1: IPv4 stage request; sampled only while `out_rdy` is high.
- `out_length`, out, 16: latched UDP length, valid while `out_rdy` is high and through transmission.
- `out_dat`, out, 8; `out_val`, `out_sof`, `out_eof`, out, 1 each: output stream.
- `err`, out, 1: one-cycle pulse on an aborted or rejected datagram.

## Operation
States: `idle_s`, `pend_s`, `hdr_s`, `pld_s`, `drop_s`.

- **`idle_s`**
  - On `in_rdy`, latch ports, length and cks into an 8-byte header register. Byte order: src hi, src lo, dst hi, dst lo, len hi, len lo, cks hi, cks lo.
  - Latch `out_length`.
  - If `in_length < 8` or `in_length > MTU-20`, go to `drop_s`. Otherwise go to `pend_s` and set `out_rdy`=1.
- **`pend_s`**
  - Wait for `out_req`, then set `out_rdy`=0, clear the byte counter and go to `hdr_s`.
  - `in_rdy` falling here is ignored, because the metadata is already latched.
- **`hdr_s`**
  - Emit header bytes 0..7 on consecutive cycles with `out_val`=1 and `out_sof`=1 on byte 0.
  - Pulse `in_req` on the cycle header byte 6 is emitted.
  - After byte 7:
    - If `in_length == 8`, byte 7 carries `out_eof`=1 and no `in_req` is issued. Return to `idle_s`.
    - Otherwise go to `pld_s`.
- **`pld_s`**
  - Each `in_val` byte is registered once and output: `out_dat`=`in_dat`, `out_val`=1.
  - `out_eof` mirrors `in_eof` one cycle later. On `in_eof`, return to `idle_s`.
  - `in_sof` is ignored; there is never a second `out_sof`.
  - The payload byte counter saturates at `in_length-8`. If `in_eof` arrives earlier or later than this count, the frame is still terminated on `in_eof` and `err` pulses together with `out_eof`.
  - If `in_val` is low for `TIMEOUT` consecutive cycles: emit one byte 0x00 with `out_val`=1 and `out_eof`=1, pulse `err`, and go to `idle_s`.
- **`drop_s`**
  - Pulse `in_req` once to drain upstream and pulse `err`.
  - Discard bytes until `in_eof` or `TIMEOUT`, then go to `idle_s`. No output stream is produced.
- **Reset**
  - Reset is valid in any state, including mid-frame.
  - Next state is `idle_s`. All outputs go to 0: `in_req`, `out_rdy`, `out_val`, `out_sof`, `out_eof`, `err`, `out_dat`=0x00, `out_length`=0.
  - A truncated frame is not terminated; downstream is reset by the same `rst`.

## Timing
- Let T be the cycle on which `out_req` is sampled high in `pend_s`.
- Header byte k appears on cycle T+1+k, for k = 0..7.
- `in_req` is high on cycle T+7 only.
- With upstream first byte at T+8, payload byte 0 appears at T+9. The output stream is gap-free if upstream is gap-free.
- Payload latency is 1 cycle, registered.
- `out_rdy` is asserted 1 cycle after `in_rdy` is sampled in `idle_s`, and deasserted on T+1.
- The block is back in `idle_s` on the cycle after `out_eof`. It may accept a new `in_rdy` on that cycle, so the minimum inter-frame gap is 1 cycle.
- `out_req` outside `pend_s` is ignored.

## Test plan
- **Normal frame:** src=0x1234, dst=0x0050, len=12 (4 payload bytes AA BB CC DD) → out: 12 34 00 50 00 0C 00 00 AA BB CC DD on cycles T+1..T+12. `out_sof` at T+1, `out_eof` at T+12, `in_req` at T+7 only, `err`=0.
- **Header-only:** len=8 → 8 header bytes, `out_eof` on byte 7, no `in_req` pulse.
- **Back-to-back:** two frames, len=10 each, `in_rdy` held → second `out_rdy` asserts 1 cycle after the first frame's `out_eof`. Ports in the second header reflect the second metadata.
- **Underrun:** `in_val` drops after 2 of 4 payload bytes and stays low for 8 cycles → trailing 0x00 byte with `out_eof` and `err` pulse, state returns to idle.
- **Reject:** len=5 and len=1500 → no `out_rdy`, one `in_req`, upstream bytes drained, `err` pulses once per datagram.
- **Mid-frame reset:** `rst` at T+4 → all outputs 0 on the following cycle. A subsequent len=10 frame is transmitted correctly.
